word_unpacker: RTL and testbench

//  Parametrised decryption back-end. Takes WORD_W-bit plaintext words from the modular-exponentiation core.

---
 rtl/word_unpacker_pkg.sv | 21 ++
 rtl/word_unpacker_fifo.sv | 47 ++++
 rtl/word_unpacker.sv | 182 ++++++++++++++++++
 tb/tb_word_unpacker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_unpacker_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the word unpacker.
package word_unpacker_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SIZING = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_SEND   = 3'd4
  } state_e;

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/word_unpacker_fifo.sv
// DEPTH x W synchronous show-ahead FIFO; a push while full is dropped and flagged on ovf.
module word_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         wr_en, rd_en;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    ovf      = push && full;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    dout     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/word_unpacker.sv
// Strips zero padding from decrypted words and re-serialises the payload into UART characters.
// Define WORD_UNPACKER_FLUSH_EN to send a trailing partial character (right-aligned) at completion.
module word_unpacker
  import word_unpacker_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] n_key,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              last_word_tick,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              sending_word,
  output logic              done_tick,
  output logic              overflow
);
  localparam int NL_W = cnt_w(WORD_W);
  localparam int BC_W = cnt_w(BYTE_W);

  state_e            state_q, state_d;
  logic [NL_W-1:0]   n_len_q, n_len_d, pack_cnt_q, pack_cnt_d;
  logic [WORD_W-1:0] key_buf_q, key_buf_d, pack_q, pack_d;
  logic [BYTE_W-1:0] byte_q, byte_d, tx_data_q, tx_data_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              fin_q, fin_d, tx_busy_q, tx_busy_d, tx_start_q, tx_start_d;
  logic              done_q, done_d, last_pend_q, last_pend_d, overflow_q, overflow_d;

  logic              fifo_pop, fifo_full, fifo_empty, fifo_ovf, fifo_last;
  logic [WORD_W:0]   fifo_dout;
  logic [WORD_W-1:0] fifo_word;
  logic              fire, word_end;

  word_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (word_valid),
    .din   ({last_pend_q, word_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .ovf   (fifo_ovf)
  );

  assign fifo_last    = fifo_dout[WORD_W];
  assign fifo_word    = fifo_dout[WORD_W-1:0];
  assign word_ready   = !fifo_full;
  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign done_tick    = done_q;
  assign overflow     = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      n_len_q     <= '0;
      pack_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      fin_q       <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      done_q      <= 1'b0;
      last_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_len_q     <= n_len_d;
      pack_cnt_q  <= pack_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      fin_q       <= fin_d;
      tx_busy_q   <= tx_busy_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      done_q      <= done_d;
      last_pend_q <= last_pend_d;
      overflow_q  <= overflow_d;
    end
    key_buf_q <= key_buf_d;
    pack_q    <= pack_d;
    byte_q    <= byte_d;
  end

  always_comb begin
    state_d    = state_q;
    n_len_d    = n_len_q;
    key_buf_d  = key_buf_q;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    byte_d     = byte_q;
    byte_cnt_d = byte_cnt_q;
    fin_d      = fin_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    word_end   = (pack_cnt_q == n_len_q - NL_W'(1));
    case (state_q)
      ST_IDLE: begin
        n_len_d    = '0;
        key_buf_d  = n_key;
        byte_cnt_d = '0;
        fin_d      = 1'b0;
        if (start) state_d = ST_SIZING;
      end
      ST_SIZING: begin
        if (key_buf_q != '0) begin
          n_len_d   = n_len_q + NL_W'(1);
          key_buf_d = key_buf_q >> 1;
        end else if (n_len_q < NL_W'(2)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          pack_d     = fifo_word;
          pack_cnt_d = '0;
          fin_d      = fifo_last;
          state_d    = ST_SHIFT;
        end else if (fin_q) begin
`ifdef WORD_UNPACKER_FLUSH_EN
          // The partial character sits in the top byte_cnt bits; slide it down to bit 0.
          if (byte_cnt_q != '0) begin
            byte_d  = byte_q >> (BC_W'(BYTE_W) - byte_cnt_q);
            state_d = ST_SEND;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
`else
          done_d  = 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end
      ST_SHIFT: begin
        pack_d     = pack_q >> 1;
        byte_d     = {pack_q[0], byte_q[BYTE_W-1:1]};
        pack_cnt_d = pack_cnt_q + NL_W'(1);
        byte_cnt_d = byte_cnt_q + BC_W'(1);
        if (byte_cnt_d == BC_W'(BYTE_W)) state_d = ST_SEND;
        else if (pack_cnt_d == n_len_q - NL_W'(1)) state_d = ST_LOAD;
      end
      ST_SEND: begin
        if (fire) begin
          byte_cnt_d = '0;
          state_d    = word_end ? ST_LOAD : ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sending_word = (state_q == ST_SHIFT) || (state_q == ST_SEND);
    fire         = (state_q == ST_SEND) && !tx_busy_q;
    tx_start_d   = fire;
    tx_data_d    = fire ? byte_q : tx_data_q;
    // A done tick landing on the tx_start cycle belongs to the previous character.
    if (fire) tx_busy_d = 1'b1;
    else if (tx_done_tick && !tx_start_q) tx_busy_d = 1'b0;
    else tx_busy_d = tx_busy_q;
    last_pend_d = last_pend_q;
    if (word_valid && word_ready && last_pend_q) last_pend_d = 1'b0;
    if (last_word_tick) last_pend_d = 1'b1;
    overflow_d = overflow_q | fifo_ovf;
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Randomised self-checking bench for word_unpacker against a bit-stream reference model.
module tb_word_unpacker;

  logic        clk = 1'b0;
  logic        rst_n, start, word_valid, word_ready, last_word_tick, tx_done_tick;
  logic        tx_start, sending_word, done_tick, overflow;
  logic [31:0] n_key, word_data;
  logic [7:0]  tx_data;

  int   checks = 0, errors = 0;
  int   done_cnt = 0, cyc = 0, start_cyc = 0, done_cyc = 0, stab_err = 0;
  int   uart_dly = 20, kick_req = 0;
  bit   auto_en = 1'b1, coincide = 1'b0;
  logic [7:0]  got_q[$];
  logic [31:0] words_q[$];

  word_unpacker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .n_key          (n_key),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_ready     (word_ready),
    .last_word_tick (last_word_tick),
    .tx_done_tick   (tx_done_tick),
    .tx_start       (tx_start),
    .tx_data        (tx_data),
    .sending_word   (sending_word),
    .done_tick      (done_tick),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: collects characters and completion pulses, watches tx_data stability.
  initial begin
    logic [7:0] last_tx;
    last_tx = 8'h00;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (tx_start) begin got_q.push_back(tx_data); start_cyc = cyc; end
      if (done_tick) begin done_cnt++; done_cyc = cyc; end
      if (tx_start || !rst_n) last_tx = tx_data;
      else if (tx_data !== last_tx) stab_err++;
    end
  end

  // UART model: done tick after uart_dly cycles, or coincident with tx_start, or on request.
  initial begin
    int dly_cnt, kick_ack;
    dly_cnt = 0; kick_ack = 0;
    tx_done_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_done_tick = 1'b0;
      if (tx_start && coincide) tx_done_tick = 1'b1;
      else if (tx_start && auto_en) dly_cnt = uart_dly;
      else if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) tx_done_tick = 1'b1;
      end
      if (kick_req != kick_ack) begin tx_done_tick = 1'b1; kick_ack = kick_req; end
    end
  end

  function automatic int bitlen(input logic [31:0] k);
    int n = 0;
    while (k != 0) begin n++; k = k >> 1; end
    return n;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Entered and left on a negedge; holds valid for one cycle once the FIFO has room.
  task automatic push_word(input logic [31:0] w, input logic tick);
    int t = 0;
    while (!word_ready && t < 2000) begin @(negedge clk); t++; end
    check_val("push_rdy", 32'(word_ready), 32'(1));
    word_valid = 1'b1; word_data = w; last_word_tick = tick;
    @(negedge clk);
    word_valid = 1'b0; last_word_tick = 1'b0;
  endtask

  task automatic start_session(input logic [31:0] key);
    @(negedge clk);
    n_key = key; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_session(input logic [31:0] key, input bit tick_coinc, input int dly, input string tag);
    int nl, pl, g0, d0, t, nw;
    bit bits_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] b8;
    bit flushed = 1'b0;
    nl = bitlen(key);
    pl = (nl < 2) ? 0 : nl - 1;
    nw = words_q.size();
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < pl; b++) bits_q.push_back(words_q[i][b]);
    while (bits_q.size() >= 8) begin
      b8 = '0;
      for (int j = 0; j < 8; j++) b8[j] = bits_q.pop_front();
      exp_q.push_back(b8);
    end
`ifdef WORD_UNPACKER_FLUSH_EN
    if (bits_q.size() > 0) begin
      b8 = '0;
      for (int j = 0; bits_q.size() > 0; j++) b8[j] = bits_q.pop_front();
      exp_q.push_back(b8);
      flushed = 1'b1;
    end
`endif
    uart_dly = dly; auto_en = 1'b1; coincide = 1'b0;
    g0 = got_q.size(); d0 = done_cnt;
    start_session(key);
    for (int i = 0; i < nw; i++) begin
      if (i == nw - 1) begin
        if (!tick_coinc || nw == 1) begin
          last_word_tick = 1'b1;
          @(negedge clk);
          last_word_tick = 1'b0;
        end
        push_word(words_q[i], 1'b0);
      end else begin
        push_word(words_q[i], tick_coinc && (i == nw - 2));
      end
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check_val({tag, "_done"}, 32'(done_cnt - d0), 32'(1));
    check_val({tag, "_nchar"}, 32'(got_q.size() - g0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++)
      check_val($sformatf("%s_c%0d", tag, i), 32'(got_q[g0 + i]), 32'(exp_q[i]));
    if (flushed) check_val({tag, "_flush_lat"}, 32'(done_cyc - start_cyc), 32'(1));
    check_val({tag, "_idle"}, 32'(sending_word), 32'(0));
    if (t >= 5000) do_reset();
    repeat (30) @(negedge clk);
  endtask

  task automatic size_only(input logic [31:0] key, input string tag);
    int g0, d0, k;
    g0 = got_q.size(); d0 = done_cnt; k = 0;
    @(negedge clk);
    n_key = key; start = 1'b1;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_cnt != d0) k = i;
    end
    start = 1'b0;
    check_val({tag, "_lat_ok"}, 32'(k >= 1 && k <= 3), 32'(1));
    repeat (5) @(negedge clk);
    check_val({tag, "_ndone"}, 32'(done_cnt - d0), 32'(1));
    check_val({tag, "_nchar"}, 32'(got_q.size() - g0), 32'(0));
  endtask

  initial begin
    int g0, d0, t, nl, nw;
    logic [63:0] m;
    logic [31:0] key;
    rst_n = 1'b0; start = 1'b0; n_key = '0; word_valid = 1'b0; word_data = '0;
    last_word_tick = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 32'(word_ready), 32'(1));
    check_val("rst_txstart", 32'(tx_start), 32'(0));
    check_val("rst_txdata", 32'(tx_data), 32'(0));
    check_val("rst_sending", 32'(sending_word), 32'(0));
    check_val("rst_done", 32'(done_tick), 32'(0));
    check_val("rst_ovf", 32'(overflow), 32'(0));
    rst_n = 1'b1;

    words_q = {32'h41, 32'h42};
    run_session(32'h1FF, 1'b0, 20, "t1");
    words_q = {32'h1, 32'h2};
    run_session(32'h11, 1'b0, 20, "t2");
    words_q = {32'hA};
    run_session(32'h11, 1'b0, 20, "t4");
    size_only(32'h1, "t5_key1");
    size_only(32'h0, "t5_key0");

    // FIFO fill and sticky overflow
    auto_en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      word_valid = 1'b1; word_data = 32'(i);
      @(negedge clk);
      check_val($sformatf("t3_rdy%0d", i), 32'(word_ready), 32'(i < 4));
      check_val($sformatf("t3_ovf%0d", i), 32'(overflow), 32'(i >= 5));
    end
    word_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_val("t3_ovf_hold", 32'(overflow), 32'(1));
    do_reset();
    check_val("t3_ovf_clr", 32'(overflow), 32'(0));
    check_val("t3_rdy_clr", 32'(word_ready), 32'(1));

    // tx_done coincident with tx_start must not release the next character
    coincide = 1'b1; auto_en = 1'b0;
    g0 = got_q.size(); d0 = done_cnt;
    start_session(32'h1FF);
    push_word(32'h55, 1'b0);
    push_word(32'h66, 1'b0);
    last_word_tick = 1'b1;
    @(negedge clk);
    last_word_tick = 1'b0;
    push_word(32'h77, 1'b0);
    t = 0;
    while (got_q.size() == g0 && t < 1000) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    check_val("t5c_hold", 32'(got_q.size() - g0), 32'(1));
    coincide = 1'b0; auto_en = 1'b1; uart_dly = 5; kick_req++;
    t = 0;
    while (done_cnt == d0 && t < 2000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    check_val("t5c_nchar", 32'(got_q.size() - g0), 32'(3));
    if (got_q.size() - g0 == 3) begin
      check_val("t5c_c0", 32'(got_q[g0]), 32'h55);
      check_val("t5c_c1", 32'(got_q[g0 + 1]), 32'h66);
      check_val("t5c_c2", 32'(got_q[g0 + 2]), 32'h77);
    end
    check_val("t5c_done", 32'(done_cnt - d0), 32'(1));
    repeat (30) @(negedge clk);

    // Reset during SHIFT aborts the session
    start_session(32'h1FF);
    push_word(32'h41, 1'b0);
    t = 0;
    while (!sending_word && t < 200) begin @(negedge clk); t++; end
    check_val("t6_in_shift", 32'(sending_word), 32'(1));
    d0 = done_cnt;
    do_reset();
    check_val("t6_txstart", 32'(tx_start), 32'(0));
    check_val("t6_txdata", 32'(tx_data), 32'(0));
    check_val("t6_sending", 32'(sending_word), 32'(0));
    check_val("t6_done", 32'(done_tick), 32'(0));
    check_val("t6_ovf", 32'(overflow), 32'(0));
    check_val("t6_ready", 32'(word_ready), 32'(1));
    repeat (30) @(negedge clk);
    check_val("t6_nodone", 32'(done_cnt - d0), 32'(0));
    words_q = {32'h41, 32'h42};
    run_session(32'h1FF, 1'b0, 20, "t6r");

    for (int s = 0; s < 20; s++) begin
      nl  = $urandom_range(32, 2);
      m   = (64'd1 << nl) - 64'd1;
      key = 32'((64'($urandom) & m) | (64'd1 << (nl - 1)));
      m   = (64'd1 << (nl - 1)) - 64'd1;
      nw  = $urandom_range(6, 1);
      words_q.delete();
      for (int i = 0; i < nw; i++) words_q.push_back(32'(64'($urandom) & m));
      run_session(key, 1'($urandom_range(1, 0)), $urandom_range(25, 1), $sformatf("rnd%0d", s));
    end

    check_val("tx_data_stable", 32'(stab_err), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
